// File: rtl/nibble_timer_ctrl_pkg.sv
// Shared constants for the nibble timer controller: FSM encoding, slice width
// and the prescaler width helper.
package nibble_timer_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/nibble_timer_ctrl_if.sv
// Control/status bundle between a timer client and nibble_timer_ctrl.
interface nibble_timer_ctrl_if #(
    parameter int N_SLICES = 4
);
    import nibble_timer_ctrl_pkg::*;

    localparam int W = SLICE_W * N_SLICES;

    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] period;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         done;

    modport master (
        output start, stop, pause, auto_reload, period,
        input  count, busy, paused, done
    );

    modport slave (
        input  start, stop, pause, auto_reload, period,
        output count, busy, paused, done
    );

endinterface

// File: rtl/nibble_timer_ctrl_down_counter.sv
// One 4-bit down-counter slice with load and a ripple borrow toward the next slice.
module nibble_down_counter
    import nibble_timer_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SLICE_W-1:0] d,
    input  logic               en,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] q,
    output logic               borrow_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= q - 1'b1;
        end
    end

    assign borrow_out = borrow_in & (q == '0);

endmodule

// File: rtl/nibble_timer_ctrl.sv
// Interval timer: FSM, prescaler and expiry detect driving a chain of
// nibble_down_counter slices that hold the remaining count.
module nibble_timer_ctrl
    import nibble_timer_ctrl_pkg::*;
#(
    parameter int N_SLICES = 4,
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    nibble_timer_ctrl_if.slave bus
);

    localparam int W  = SLICE_W * N_SLICES;
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : int'(clog2(PRESCALE));
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [1:0]      state, state_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [W-1:0]    period_q;
    logic            reload_q;
    logic            done_q, done_nxt;
    logic            busy_q, paused_q;

    logic [W-1:0]    count_q;
    logic            tick, cnt_is_one, expire;
    logic            slice_load;
    logic [W-1:0]    slice_d;
    logic [N_SLICES:0] borrow;

    // Leaving PAUSE with pause low still counts as a qualified cycle, so a
    // pause of N cycles shifts expiry by exactly N.
    assign tick       = (state != IDLE) && !bus.pause && (presc == PRE_LAST);
    assign cnt_is_one = (count_q == W'(1));
    assign expire     = tick && cnt_is_one;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        done_nxt  = 1'b0;
        if (bus.stop) begin
            state_nxt = IDLE;
            presc_nxt = '0;
        end else if (bus.start) begin
            state_nxt = bus.pause ? PAUSE : RUN;
            presc_nxt = '0;
        end else if (state != IDLE) begin
            if (bus.pause) begin
                state_nxt = PAUSE;
            end else begin
                state_nxt = RUN;
                presc_nxt = tick ? '0 : presc + 1'b1;
                if (expire) begin
                    done_nxt = 1'b1;
                    if (!reload_q) state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            period_q <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            done_q   <= done_nxt;
            busy_q   <= (state_nxt != IDLE);
            paused_q <= (state_nxt == PAUSE);
            if (!bus.stop && bus.start) begin
                period_q <= bus.period;
                reload_q <= bus.auto_reload;
            end
        end
    end

    // Loads cover stop/start/expiry; a load overrides the decrement in each slice.
    assign slice_load = bus.stop | bus.start | expire;

    always_comb begin
        slice_d = '0;
        if (bus.stop) begin
            slice_d = '0;
        end else if (bus.start) begin
            slice_d = bus.period;
        end else if (reload_q) begin
            slice_d = period_q;
        end
    end

    assign borrow[0] = tick & ~cnt_is_one;

    for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
        nibble_down_counter u_slice (
            .clk        (clk),
            .rst        (rst),
            .load       (slice_load),
            .d          (slice_d[k*SLICE_W +: SLICE_W]),
            .en         (borrow[k]),
            .borrow_in  (borrow[k]),
            .q          (count_q[k*SLICE_W +: SLICE_W]),
            .borrow_out (borrow[k+1])
        );
    end

    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.paused = paused_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_nibble_timer_ctrl.sv
// Two timer instances (16-bit/prescale 1 and 8-bit/prescale 3) checked every
// cycle against a remaining-cycles model, plus directed boundary checks.
module tb_nibble_timer_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, stop, pause, ar;
    logic [15:0] per_a;
    logic [7:0]  per_b;

    nibble_timer_ctrl_if #(.N_SLICES(4)) ifa ();
    nibble_timer_ctrl_if #(.N_SLICES(2)) ifb ();

    assign ifa.start = start;  assign ifb.start = start;
    assign ifa.stop  = stop;   assign ifb.stop  = stop;
    assign ifa.pause = pause;  assign ifb.pause = pause;
    assign ifa.auto_reload = ar;  assign ifb.auto_reload = ar;
    assign ifa.period = per_a;
    assign ifb.period = per_b;

    nibble_timer_ctrl #(.N_SLICES(4), .PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    nibble_timer_ctrl #(.N_SLICES(2), .PRESCALE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    localparam int MW [2] = '{16, 8};
    localparam int PS [2] = '{1, 3};

    // Model: qualified clk cycles left until expiry; displayed count is
    // ceil(rem/PRESCALE) modulo 2^W.
    longint rem [2];
    longint pq  [2];
    bit     rl [2], run [2], pz [2], dn [2];

    int tests = 0;
    int fails = 0;

    task automatic model_edge();
        longint p;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? longint'(per_a) : longint'(per_b);
            dn[d] = 1'b0;
            if (rst) begin
                rem[d] = 0; pq[d] = 0; rl[d] = 0; run[d] = 0; pz[d] = 0;
            end else if (stop) begin
                rem[d] = 0; run[d] = 0; pz[d] = 0;
            end else if (start) begin
                pq[d]  = (p == 0) ? (longint'(1) << MW[d]) : p;
                rl[d]  = ar;
                rem[d] = pq[d] * PS[d];
                run[d] = 1'b1;
                pz[d]  = pause;
            end else if (run[d]) begin
                if (pause) begin
                    pz[d] = 1'b1;
                end else begin
                    pz[d] = 1'b0;
                    rem[d]--;
                    if (rem[d] == 0) begin
                        dn[d] = 1'b1;
                        if (rl[d]) rem[d] = pq[d] * PS[d];
                        else run[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_count(input int d);
        if (rem[d] == 0) return 32'd0;
        return 32'(((rem[d] + PS[d] - 1) / PS[d]) % (longint'(1) << MW[d]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_count",  32'(ifa.count),  exp_count(0));
        chk("a_busy",   32'(ifa.busy),   32'(run[0]));
        chk("a_paused", 32'(ifa.paused), 32'(pz[0] & run[0]));
        chk("a_done",   32'(ifa.done),   32'(dn[0]));
        chk("b_count",  32'(ifb.count),  exp_count(1));
        chk("b_busy",   32'(ifb.busy),   32'(run[1]));
        chk("b_paused", 32'(ifb.paused), 32'(pz[1] & run[1]));
        chk("b_done",   32'(ifb.done),   32'(dn[1]));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; ar = 1'b0;
        per_a = '0; per_b = '0;
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; pq[d] = 0; rl[d] = 0; run[d] = 0; pz[d] = 0; dn[d] = 0;
        end
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_count", 32'(ifa.count), 32'd0);

        // One-shot, period 5: done and busy-fall together after edge 5.
        per_a = 16'd5; per_b = 8'd2; ar = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("oneshot_load", 32'(ifa.count), 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) chk("oneshot_early_done", 32'(ifa.done), 32'd0);
        end
        chk("oneshot_done", 32'(ifa.done), 32'd1);
        chk("oneshot_busy", 32'(ifa.busy), 32'd0);
        repeat (3) step();

        // Auto-reload, period 3, then stop at edge 13.
        per_a = 16'd3; ar = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 12) chk("reload_done12", 32'(ifa.done), 32'd1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("reload_stop_busy", 32'(ifa.busy), 32'd0);
        repeat (4) step();

        // Pause for four cycles delays one-shot expiry from edge 6 to edge 10.
        per_a = 16'd6; ar = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        repeat (4) step();
        chk("pause_paused", 32'(ifa.paused), 32'd1);
        pause = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            step();
            if (k == 9) chk("pause_early_done", 32'(ifa.done), 32'd0);
        end
        chk("pause_done", 32'(ifa.done), 32'd1);
        repeat (2) step();

        // Restart with a shorter period discards the first interval.
        per_a = 16'd8; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        per_a = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_load", 32'(ifa.count), 32'd2);
        step();
        step();
        chk("restart_done", 32'(ifa.done), 32'd1);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("stop_beats_start", 32'(ifa.busy), 32'd0);

        // Reset in the middle of a run.
        per_a = 16'd10; ar = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("midrun_rst_count", 32'(ifa.count), 32'd0);
        step();

        // 8-bit wrap at prescale 3: period 0 expires after 768 edges.
        per_a = 16'd40; per_b = 8'd0; ar = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 768; k++) begin
            step();
            if (k == 3)   chk("wrap_ff", 32'(ifb.count), 32'hFF);
            if (k == 767) chk("wrap_early_done", 32'(ifb.done), 32'd0);
        end
        chk("wrap_done", 32'(ifb.done), 32'd1);
        step();

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            ar    = 1'($urandom_range(0, 1));
            per_a = 16'($urandom_range(0, 9));
            per_b = 8'($urandom_range(0, 6));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
